mips_avl_arbiter: RTL and testbench
===================================

// Module: mips_avl_arbiter
// PURPOSE
//  Two-master Avalon-MM arbiter sharing one memory slave (avl_slave_mem) between the instruction-fetch (I)
//  and data (D) ports of the Harvard core, so it can run on the single-bus mips_cpu_bus top level.
//  Registered round-robin grant, one transfer in flight, grant held until slave drops waitrequest.
// PARAMETERS
//  ADDR_W      32  address width, all ports
//  DATA_W      32  data width; byteenable width = DATA_W/8
//  D_FIRST     1   winner when both request from IDLE with no history (1 = D, 0 = I)
// PORTS
//  clk            in   1       clock, all state on rising edge
//  reset          in   1       asynchronous, active-low reset
//  i_address      in   ADDR_W  I-master address (I side is read-only)
//  i_read         in   1       I-master read request
//  i_readdata     out  DATA_W  slave readdata forwarded to I
//  i_waitrequest  out  1       stall to I
//  d_address      in   ADDR_W  D-master address
//  d_read         in   1       D-master read request
//  d_write        in   1       D-master write request
//  d_writedata    in   DATA_W  D-master write data
//  d_byteenable   in   DATA_W/8 D-master byte lanes
//  d_readdata     out  DATA_W  slave readdata forwarded to D
//  d_waitrequest  out  1       stall to D
//  address        out  ADDR_W  to slave
//  read, write    out  1       to slave
//  writedata      out  DATA_W  to slave
//  byteenable     out  DATA_W/8 to slave
//  readdata       in   DATA_W  from slave
//  waitrequest    in   1       from slave
//  protocol_err   out  1       sticky: master violated Avalon hold rules
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, last=none, protocol_err=0. While IDLE: read=write=0, address=0,
//    writedata=0, byteenable=0; i_waitrequest=d_waitrequest=1; i_/d_readdata=0.
//  - States IDLE, GNT_I, GNT_D. Master requests: reqI=i_read, reqD=d_read|d_write.
//  - IDLE: sample requests; one requester -> grant it next cycle; both -> the one not served last;
//    no history -> D_FIRST. Arbitration latency: 1 cycle (request seen in IDLE, forwarded next cycle).
//  - GNT_x: granted master's address/read/write/writedata/byteenable passed combinationally to slave;
//    slave waitrequest passed combinationally to granted master's waitrequest; readdata forwarded to
//    granted master; other master sees waitrequest=1, readdata=0. I side: write=0, byteenable=all ones.
//  - Completion: cycle in GNT_x with slave waitrequest=0 and request asserted. Set last=x. Next state:
//    other master requesting in that cycle -> GNT_other (back-to-back, no IDLE bubble); else IDLE.
//  - Slave waitrequest=1: stay in GNT_x, outputs stable; no timeout.
//  - Granted master drops request while waitrequest=1 -> protocol_err=1, return to IDLE next cycle.
//  - Granted master changes address/writedata/byteenable while waitrequest=1, or D asserts read and write
//    together -> protocol_err=1; transfer continues. protocol_err clears only on reset.
//  - Reset mid-transfer: immediate IDLE; slave read/write drop asynchronously.
//  - No wrap/width arithmetic; data is passed unmodified.
// STRUCTURE
//  - Package mips_avl_pkg: typedef enum logic[1:0] {ARB_IDLE, ARB_GNT_I, ARB_GNT_D} arb_state_t;
//    typedef enum logic[1:0] {MST_NONE, MST_I, MST_D} mst_id_t; localparam AVL_BE_ALL.
//  - Sub-module avl_rr_pick2: combinational 2-way round-robin picker (reqI, reqD, last, D_FIRST -> winner).
//  - Top: state/last registers, output mux, protocol checker; SVA for one-hot grant and hold rules.
// TESTING (bench: arbiter + avl_slave_mem with random waitrequest option, TIMEOUT_CYCLES watchdog)
//  1. Reset, I read 0xBFC00000 alone, slave wait 2 cycles -> I sees waitrequest 1,1,1,0; readdata = mem word;
//     d_waitrequest stays 1; state IDLE after.
//  2. I and D request same cycle from reset, D_FIRST=1 -> D granted first, I granted next cycle after D
//     completes (no IDLE between); then both again -> I wins (round-robin).
//  3. D write 0xDEADBEEF byteenable 4'b0011 to 0x1000, then D read 0x1000 -> readdata 0x0000BEEF over
//     zero-initialised memory; slave never sees overlapping read/write.
//  4. Both masters requesting continuously for 20 transfers -> grants strictly alternate I,D,I,D; no
//     master waits more than one other transfer.
//  5. Granted D drops d_write while waitrequest=1 -> protocol_err=1 next edge, IDLE, stays set until reset.
//  6. Assert reset (0) mid-transfer with waitrequest=1 -> read/write=0 same time step, both master
//     waitrequests=1; after release, fresh I read completes normally.

Source files
------------

// File: rtl/mips_avl_pkg.sv
// Shared types for the two-master Avalon-MM arbiter.
//   arb_state_t : arbiter FSM states (idle, granted to I, granted to D)
//   mst_id_t    : master identity, used for the round-robin history
//   AVL_BE_ALL  : all-lanes byteenable for the default 32-bit data path
package mips_avl_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    MST_NONE = 2'd0,
    MST_I    = 2'd1,
    MST_D    = 2'd2
  } mst_id_t;

  localparam logic [3:0] AVL_BE_ALL = 4'hF;

endpackage

// File: rtl/avl_rr_pick2.sv
// Combinational two-way round-robin picker.
//   req_i, req_d : requests from the I and D masters
//   last         : master that completed the most recent transfer
//   winner       : master to grant (MST_NONE when nobody requests)
// With both requesting, the master not served last wins; with no history
// the tie goes to D when D_FIRST is set, otherwise to I.
module avl_rr_pick2
  import mips_avl_pkg::*;
#(
  parameter bit D_FIRST = 1'b1
) (
  input  logic    req_i,
  input  logic    req_d,
  input  mst_id_t last,
  output mst_id_t winner
);

  always_comb begin
    winner = MST_NONE;
    if (req_i && req_d) begin
      if (last == MST_I)      winner = MST_D;
      else if (last == MST_D) winner = MST_I;
      else                    winner = D_FIRST ? MST_D : MST_I;
    end else if (req_d) begin
      winner = MST_D;
    end else if (req_i) begin
      winner = MST_I;
    end
  end

endmodule

// File: rtl/mips_avl_arbiter.sv
// Two-master Avalon-MM arbiter: instruction fetch (I, read-only) and data (D)
// share one memory slave. Registered round-robin grant, one transfer in
// flight, grant held until the slave drops waitrequest.
// Ports:
//   clk, reset                 clock; asynchronous active-low reset
//   i_address/i_read           I master request; i_readdata/i_waitrequest back
//   d_address/d_read/d_write/
//   d_writedata/d_byteenable   D master request; d_readdata/d_waitrequest back
//   address/read/write/
//   writedata/byteenable       to slave; readdata/waitrequest from slave
//   protocol_err               sticky flag: a master broke the Avalon hold rules
//   dbg_state                  current FSM state (arb_state_t encoding)
// Handshake: a transfer completes on a rising edge where the granted master
// holds its request and the slave's waitrequest is low; until then the
// master must keep its command, address and data stable.
module mips_avl_arbiter
  import mips_avl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter bit D_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   i_address,
  input  logic                i_read,
  output logic [DATA_W-1:0]   i_readdata,
  output logic                i_waitrequest,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [DATA_W-1:0]   d_writedata,
  input  logic [DATA_W/8-1:0] d_byteenable,
  output logic [DATA_W-1:0]   d_readdata,
  output logic                d_waitrequest,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   readdata,
  input  logic                waitrequest,
  output logic                protocol_err,
  output logic [1:0]          dbg_state
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t state, next_state;
  mst_id_t    last, next_last, winner;

  logic req_i, req_d, gnt_any, gnt_req, err_set, hold_set, hold_changed;

  // Command presented by the granted master (all zero while idle).
  logic [ADDR_W-1:0] cur_addr,  hold_addr;
  logic [DATA_W-1:0] cur_wdata, hold_wdata;
  logic [BE_W-1:0]   cur_be,    hold_be;
  logic [1:0]        cur_rw,    hold_rw;
  logic              hold_valid;

  assign req_i     = i_read;
  assign req_d     = d_read | d_write;
  assign gnt_any   = (state != ARB_IDLE);
  assign dbg_state = state;

  avl_rr_pick2 #(.D_FIRST(D_FIRST)) u_pick (
    .req_i  (req_i),
    .req_d  (req_d),
    .last   (last),
    .winner (winner)
  );

  always_comb begin
    cur_addr  = '0;
    cur_wdata = '0;
    cur_be    = '0;
    cur_rw    = 2'b00;
    gnt_req   = 1'b0;
    case (state)
      ARB_GNT_I: begin
        cur_addr = i_address;
        cur_be   = '1;
        cur_rw   = {i_read, 1'b0};
        gnt_req  = req_i;
      end
      ARB_GNT_D: begin
        cur_addr  = d_address;
        cur_wdata = d_writedata;
        cur_be    = d_byteenable;
        cur_rw    = {d_read, d_write};
        gnt_req   = req_d;
      end
      default: ;
    endcase
  end

  // Slave side is a straight mux of the granted command.
  always_comb begin
    address       = cur_addr;
    read          = cur_rw[1];
    write         = cur_rw[0];
    writedata     = cur_wdata;
    byteenable    = cur_be;
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    i_readdata    = '0;
    d_readdata    = '0;
    if (state == ARB_GNT_I) begin
      i_waitrequest = waitrequest;
      i_readdata    = readdata;
    end else if (state == ARB_GNT_D) begin
      d_waitrequest = waitrequest;
      d_readdata    = readdata;
    end
  end

  // Completion hands straight to the other master if it is already
  // requesting, so back-to-back transfers have no idle bubble.
  always_comb begin
    next_state = state;
    next_last  = last;
    case (state)
      ARB_IDLE: begin
        if (winner == MST_I)      next_state = ARB_GNT_I;
        else if (winner == MST_D) next_state = ARB_GNT_D;
      end
      ARB_GNT_I: begin
        if (!req_i) begin
          next_state = ARB_IDLE;
        end else if (!waitrequest) begin
          next_last  = MST_I;
          next_state = req_d ? ARB_GNT_D : ARB_IDLE;
        end
      end
      ARB_GNT_D: begin
        if (!req_d) begin
          next_state = ARB_IDLE;
        end else if (!waitrequest) begin
          next_last  = MST_D;
          next_state = req_i ? ARB_GNT_I : ARB_IDLE;
        end
      end
      default: next_state = ARB_IDLE;
    endcase
  end

  // The command seen on a stalled cycle must reappear unchanged on the next.
  assign hold_set     = gnt_any && waitrequest && gnt_req;
  assign hold_changed = hold_valid &&
                        ({cur_addr, cur_wdata, cur_be, cur_rw} !=
                         {hold_addr, hold_wdata, hold_be, hold_rw});
  assign err_set      = (d_read && d_write) ||
                        (gnt_any && waitrequest && !gnt_req) ||
                        hold_changed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ARB_IDLE;
      last         <= MST_NONE;
      protocol_err <= 1'b0;
      hold_valid   <= 1'b0;
      hold_addr    <= '0;
      hold_wdata   <= '0;
      hold_be      <= '0;
      hold_rw      <= 2'b00;
    end else begin
      state      <= next_state;
      last       <= next_last;
      hold_valid <= hold_set;
      if (err_set) protocol_err <= 1'b1;
      if (hold_set) begin
        hold_addr  <= cur_addr;
        hold_wdata <= cur_wdata;
        hold_be    <= cur_be;
        hold_rw    <= cur_rw;
      end
    end
  end

  a_one_grant: assert property (@(posedge clk) disable iff (!reset)
    !(!i_waitrequest && !d_waitrequest));
  a_i_no_write: assert property (@(posedge clk) disable iff (!reset)
    (state == ARB_GNT_I) |-> !write);
  a_grant_held: assert property (@(posedge clk) disable iff (!reset)
    (gnt_any && waitrequest && gnt_req) |=> (state == $past(state)));

endmodule

// File: tb/tb_mips_avl_arbiter.sv
module tb_mips_avl_arbiter;

  localparam int TIMEOUT_CYCLES = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_address, d_address, d_writedata, address, writedata, readdata;
  logic [31:0] i_readdata, d_readdata;
  logic        i_read, i_waitrequest, d_read, d_write, d_waitrequest;
  logic [3:0]  d_byteenable, byteenable;
  logic        read, write, waitrequest, protocol_err;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  mips_avl_arbiter #(.ADDR_W(32), .DATA_W(32), .D_FIRST(1'b1)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_address     (i_address),
    .i_read        (i_read),
    .i_readdata    (i_readdata),
    .i_waitrequest (i_waitrequest),
    .d_address     (d_address),
    .d_read        (d_read),
    .d_write       (d_write),
    .d_writedata   (d_writedata),
    .d_byteenable  (d_byteenable),
    .d_readdata    (d_readdata),
    .d_waitrequest (d_waitrequest),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .waitrequest   (waitrequest),
    .protocol_err  (protocol_err),
    .dbg_state     (dbg_state)
  );

  // ---------------- memory slave model ----------------
  // Waitrequest is high by default and for slv_wait cycles of each access.
  logic [31:0] rom_init [0:4095];
  logic [31:0] wr_mem   [0:4095];
  logic        wr_valid [0:4095];
  int          slv_wait = 0;
  int          cnt = 0;
  int          cyc = 0;
  logic        overlap_seen = 1'b0;
  logic [31:0] got_q[$];
  int          cyc_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] cur_word, merged;

  assign waitrequest = !(read || write) || (cnt < slv_wait);
  assign cur_word    = wr_valid[address[13:2]] ? wr_mem[address[13:2]] : rom_init[address[13:2]];
  assign readdata    = cur_word;

  always_comb begin
    merged = cur_word;
    for (int b = 0; b < 4; b++)
      if (byteenable[b]) merged[8*b +: 8] = writedata[8*b +: 8];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset) cnt <= 0;
    else if (!(read || write) || !waitrequest) cnt <= 0;
    else cnt <= cnt + 1;
    if (reset && read && write) overlap_seen <= 1'b1;
    if (reset && (read || write) && !waitrequest) begin
      got_q.push_back((dbg_state == 2'd1) ? 32'd1 : 32'd2);
      cyc_q.push_back(cyc);
      if (write) begin
        wr_mem[address[13:2]]   <= merged;
        wr_valid[address[13:2]] <= 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    reset = 1'b0;
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0; d_byteenable = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic i_read_op(input logic [31:0] a, output logic [31:0] data);
    logic done;
    done = 1'b0; data = '0;
    i_address = a; i_read = 1'b1;
    for (int n = 0; n < TIMEOUT_CYCLES && !done; n++) begin
      @(negedge clk);
      if (!i_waitrequest) begin data = i_readdata; done = 1'b1; end
      @(posedge clk); #1;
    end
    i_read = 1'b0;
    total++;
    if (!done) begin bad++; $display("FAIL i_timeout addr=%h got no completion want completion", a); end
  endtask

  task automatic d_op(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                      input logic [3:0] be, output logic [31:0] data);
    logic done;
    done = 1'b0; data = '0;
    d_address = a; d_read = !wr; d_write = wr; d_writedata = wd; d_byteenable = be;
    for (int n = 0; n < TIMEOUT_CYCLES && !done; n++) begin
      @(negedge clk);
      if (!d_waitrequest) begin data = d_readdata; done = 1'b1; end
      @(posedge clk); #1;
    end
    d_read = 1'b0; d_write = 1'b0;
    total++;
    if (!done) begin bad++; $display("FAIL d_timeout addr=%h got no completion want completion", a); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    i_read = 1'b0; i_address = 32'h1234_5678;
    d_read = 1'b0; d_write = 1'b0; d_address = 32'h0000_1000;
    d_writedata = 32'hCAFE_F00D; d_byteenable = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if ({read, write} !== 2'b00) begin bad++; $display("FAIL rst_rw got=%b want=00", {read, write}); end
    total++; if ({address, writedata, byteenable} !== 68'd0) begin bad++; $display("FAIL rst_slave_bus got=%h want=0", {address, writedata, byteenable}); end
    total++; if ({i_waitrequest, d_waitrequest} !== 2'b11) begin bad++; $display("FAIL rst_wait got=%b want=11", {i_waitrequest, d_waitrequest}); end
    total++; if ({i_readdata, d_readdata} !== 64'd0) begin bad++; $display("FAIL rst_readdata got=%h want=0", {i_readdata, d_readdata}); end
    total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", protocol_err); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", dbg_state); end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    total++; if ({dbg_state, address} !== 34'd0) begin bad++; $display("FAIL idle_noreq got=%h want=0", {dbg_state, address}); end
    apply_reset();
  endtask

  task automatic test_i_read_alone();
    logic [3:0]  ws;
    logic [31:0] rd;
    rom_init[0] = 32'h3C1D_BFC0;
    slv_wait = 2;
    rd = '0;
    i_address = 32'hBFC0_0000; i_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ws[3-k] = i_waitrequest;
      rd = i_readdata;
      total++; if (d_waitrequest !== 1'b1) begin bad++; $display("FAIL t1_d_wait cyc=%0d got=%b want=1", k, d_waitrequest); end
      @(posedge clk); #1;
    end
    i_read = 1'b0;
    total++; if (ws !== 4'b1110) begin bad++; $display("FAIL t1_wait_seq got=%b want=1110", ws); end
    total++; if (rd !== 32'h3C1D_BFC0) begin bad++; $display("FAIL t1_readdata got=%h want=3c1dbfc0", rd); end
    @(negedge clk);
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL t1_state_after got=%0d want=0", dbg_state); end
  endtask

  task automatic test_both_from_reset();
    logic [31:0] ird, drd, tmp;
    apply_reset();
    slv_wait = 1;
    got_q.delete(); cyc_q.delete();
    fork
      i_read_op(32'hBFC0_0000, ird);
      d_op(32'h0000_1000, 1'b0, 32'h0, 4'h0, drd);
    join
    total++; if (got_q.size() != 2 || got_q[0] !== 32'd2 || got_q[1] !== 32'd1) begin bad++; $display("FAIL t2_order got_n=%0d want=D,I", got_q.size()); end
    total++; if (cyc_q.size() != 2 || cyc_q[1] - cyc_q[0] != 2) begin bad++; $display("FAIL t2_no_bubble got_n=%0d want gap 2", cyc_q.size()); end
    total++; if (ird !== 32'h3C1D_BFC0 || drd !== 32'h0) begin bad++; $display("FAIL t2_data got=%h/%h want=3c1dbfc0/0", ird, drd); end
    // D alone first, so in the next contention I has priority
    d_op(32'h0000_1008, 1'b1, 32'h1111_1111, 4'hF, tmp);
    got_q.delete();
    fork
      i_read_op(32'hBFC0_0000, ird);
      d_op(32'h0000_1008, 1'b0, 32'h0, 4'h0, drd);
    join
    total++; if (got_q.size() != 2 || got_q[0] !== 32'd1 || got_q[1] !== 32'd2) begin bad++; $display("FAIL t2_rr got_n=%0d want=I,D", got_q.size()); end
    total++; if (drd !== 32'h1111_1111) begin bad++; $display("FAIL t2_rr_data got=%h want=11111111", drd); end
  endtask

  task automatic test_partial_write();
    logic [31:0] rd;
    slv_wait = 1;
    d_op(32'h0000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011, rd);
    d_op(32'h0000_1000, 1'b0, 32'h0, 4'h0, rd);
    total++; if (rd !== 32'h0000_BEEF) begin bad++; $display("FAIL t3_be_read got=%h want=0000beef", rd); end
    total++; if (overlap_seen !== 1'b0) begin bad++; $display("FAIL t3_overlap got=%b want=0", overlap_seen); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] idata [10];
    logic [31:0] ddata [10];
    logic [31:0] e;
    for (int k = 0; k < 10; k++) begin
      rom_init[4 + k]     = 32'h1000_0000 + k;
      rom_init[12'h800 + k] = 32'h2000_0000 + k;
    end
    slv_wait = 1;
    got_q.delete(); exp_q.delete();
    for (int k = 0; k < 20; k++) exp_q.push_back((k % 2 == 0) ? 32'd1 : 32'd2);
    fork
      begin for (int k = 0; k < 10; k++) i_read_op(32'hBFC0_0010 + 4 * k, idata[k]); end
      begin for (int k = 0; k < 10; k++) d_op(32'h0000_2000 + 4 * k, 1'b0, 32'h0, 4'h0, ddata[k]); end
    join
    total++; if (got_q.size() != 20) begin bad++; $display("FAIL t4_count got=%0d want=20", got_q.size()); end
    for (int k = 0; k < 20 && got_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      total++; if (got_q[0] !== e) begin bad++; $display("FAIL t4_grant idx=%0d got=%0d want=%0d", k, got_q[0], e); end
      void'(got_q.pop_front());
    end
    for (int k = 0; k < 10; k++) begin
      total++; if (idata[k] !== 32'h1000_0000 + k) begin bad++; $display("FAIL t4_i_data idx=%0d got=%h want=%h", k, idata[k], 32'h1000_0000 + k); end
      total++; if (ddata[k] !== 32'h2000_0000 + k) begin bad++; $display("FAIL t4_d_data idx=%0d got=%h want=%h", k, ddata[k], 32'h2000_0000 + k); end
    end
  endtask

  task automatic test_drop_request();
    logic [31:0] rd;
    slv_wait = 3;
    d_address = 32'h0000_1004; d_writedata = 32'h5555_AAAA; d_byteenable = 4'hF; d_write = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if ({dbg_state, d_waitrequest, protocol_err} !== 4'b1010) begin bad++; $display("FAIL t5_granted got=%b want=1010", {dbg_state, d_waitrequest, protocol_err}); end
    @(posedge clk); #1;
    d_write = 1'b0;
    @(posedge clk); #1;
    total++; if (protocol_err !== 1'b1) begin bad++; $display("FAIL t5_err_set got=%b want=1", protocol_err); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL t5_idle got=%0d want=0", dbg_state); end
    total++; if (wr_valid[12'h401] === 1'b1) begin bad++; $display("FAIL t5_no_commit got=1 want=0"); end
    slv_wait = 0;
    i_read_op(32'hBFC0_0000, rd);
    total++; if (protocol_err !== 1'b1) begin bad++; $display("FAIL t5_err_sticky got=%b want=1", protocol_err); end
  endtask

  task automatic test_reset_mid_transfer();
    logic [31:0] rd;
    slv_wait = 5;
    i_address = 32'hBFC0_0000; i_read = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (read !== 1'b1) begin bad++; $display("FAIL t6_in_flight got=%b want=1", read); end
    reset = 1'b0;
    #1;
    total++; if ({read, write} !== 2'b00) begin bad++; $display("FAIL t6_rw_drop got=%b want=00", {read, write}); end
    total++; if ({i_waitrequest, d_waitrequest} !== 2'b11) begin bad++; $display("FAIL t6_wait got=%b want=11", {i_waitrequest, d_waitrequest}); end
    total++; if ({dbg_state, protocol_err} !== 3'b000) begin bad++; $display("FAIL t6_state_err got=%b want=000", {dbg_state, protocol_err}); end
    i_read = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    slv_wait = 0;
    i_read_op(32'hBFC0_0000, rd);
    total++; if (rd !== 32'h3C1D_BFC0) begin bad++; $display("FAIL t6_fresh_read got=%h want=3c1dbfc0", rd); end
    total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL t6_err_clear got=%b want=0", protocol_err); end
  endtask

  task automatic test_addr_hold();
    logic done;
    done = 1'b0;
    slv_wait = 2;
    got_q.delete();
    i_address = 32'hBFC0_0004; i_read = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_address = 32'hBFC0_0008;
    for (int n = 0; n < TIMEOUT_CYCLES && !done; n++) begin
      @(negedge clk);
      if (!i_waitrequest) done = 1'b1;
      @(posedge clk); #1;
    end
    i_read = 1'b0;
    total++; if (done !== 1'b1 || got_q.size() != 1) begin bad++; $display("FAIL t7_continues got=%b/%0d want=1/1", done, got_q.size()); end
    total++; if (protocol_err !== 1'b1) begin bad++; $display("FAIL t7_hold_err got=%b want=1", protocol_err); end
    @(negedge clk);
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL t7_idle got=%0d want=0", dbg_state); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int k = 0; k < 4096; k++) begin
      rom_init[k] = '0; wr_mem[k] = '0; wr_valid[k] = 1'b0;
    end
    test_reset();
    test_i_read_alone();
    test_both_from_reset();
    test_partial_write();
    test_back_to_back();
    test_drop_request();
    test_reset_mid_transfer();
    test_addr_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=time limit want=bench completion");
    $fatal(1, "watchdog");
  end

endmodule
